wishbone_master_adapter: RTL and testbench
==========================================

WISHBONE_MASTER_ADAPTER -- requirements
Module: wishbone_master_adapter

Interface
REQ-001 SHALL have parameter addr_width, default 32, the address width on both sides.
REQ-002 SHALL have parameter data_width, default 32, the data width on both sides.
REQ-003 SHALL have parameter strobe_width, default data_width/8, the byte-strobe width.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 SHALL have ports raddr/raddr_valid/raddr_ready, in/in/out, addr_width/1/1, the read-address channel.
REQ-007 SHALL have ports rdata/rdata_valid/rdata_ready, out/out/in, data_width/1/1, the read-data channel.
REQ-008 SHALL have ports waddr/waddr_valid/waddr_ready, in/in/out, addr_width/1/1, the write-address channel.
REQ-009 SHALL have ports wdata/wstrobe/wdata_valid/wdata_ready, in/in/in/out, data_width/strobe_width/1/1, the write-data channel.
REQ-010 SHALL have ports wresp_valid/wresp_ready, out/in, 1/1, the write-completion channel.
REQ-011 SHALL have port wb, wishbone_bus_if.m_modport, with adr_width=addr_width, dat_width=data_width and sel_width=strobe_width, as the Wishbone master side.

Function
REQ-012 SHALL be a channel transfer when valid and ready are both high on a rising clk.
REQ-013 SHALL hold the state machine in one of IDLE, READ, WRITE, RDATA or WRESP.
REQ-014 SHALL hold waddr in a one-entry register and wdata+wstrobe in another; each ready is high exactly when its register is empty, in any state.
REQ-015 SHALL treat a write as pending when both write registers are full; a read is pending when raddr_valid=1.
REQ-016 SHALL, in IDLE, grant the only pending request; when both are pending it SHALL grant opposite to last_grant, then update last_grant.
REQ-017 SHALL assert raddr_ready only in IDLE with the read granted; it may depend combinationally on raddr_valid.
REQ-018 SHALL, on a read grant, capture raddr and enter READ; registered cyc=stb=1, we=0, sel all ones, adr=captured address, starting the cycle after acceptance.
REQ-019 SHALL, on a write grant, enter WRITE; cyc=stb=1, we=1, adr/datwr/sel from the write registers, starting the next cycle.
REQ-020 SHALL hold adr/datwr/sel/we stable while cyc=1 and wait indefinitely for ack (no timeout).
REQ-021 SHALL, on ack in READ, register datrd into rdata, deassert cyc/stb the next cycle and enter RDATA (rdata_valid one cycle after ack).
REQ-022 SHALL hold rdata_valid=1 with stable rdata in RDATA until rdata_ready, then return to IDLE.
REQ-023 SHALL, on ack in WRITE, empty both write registers, deassert cyc/stb and enter WRESP; wresp_valid holds until wresp_ready, then IDLE.
REQ-024 SHALL ignore ack when cyc=0 and SHALL never start back-to-back cycles without an IDLE cycle between them.
REQ-025 SHALL let new write address/data fill freed registers during RDATA/WRESP/READ, without starting a cycle until IDLE.

Reset
REQ-026 SHALL on rst: state=IDLE, cyc=stb=we=0, adr/datwr/sel=0, rdata=0, rdata_valid=wresp_valid=0, both write registers empty, last_grant=write (so the first tie goes to read).
REQ-027 SHALL, when rst asserts mid-cycle, drop cyc/stb the next edge and discard the outstanding transfer with no response.

Structure
REQ-028 SHALL put the state enum typedef and grant encoding in package wishbone_adapter_pkg.
REQ-029 SHALL implement each write register as sub-module wishbone_hold_reg (parameter width; load on valid&ready, clear on ack), instantiated twice.

Verification
REQ-030 Read raddr=0x100, slave acks after 3 cycles with datrd=0xDEADBEEF -> one cycle with adr=0x100, we=0, sel=0xF; rdata=0xDEADBEEF with rdata_valid the cycle after ack.
REQ-031 Write waddr=0x200 a cycle before wdata=0x12345678, wstrobe=0x3 -> cycle starts after both are held; datwr=0x12345678, sel=0x3, we=1; wresp_valid follows ack.
REQ-032 Read and write pending together from reset -> read granted first, then write; with both repeatedly pending, grants alternate.
REQ-033 rdata_ready low for 5 cycles -> rdata_valid and rdata stable; no new cyc during the stall.
REQ-034 Spurious ack while cyc=0 -> no state change and no response.
REQ-035 rst asserted while cyc=1 -> cyc/stb=0 next cycle, all valids and readies return to reset values.

Source files
------------

// File: rtl/wishbone_adapter_pkg.sv
// Shared types for the Wishbone master adapter: FSM states, grant encoding
// and the read/write arbitration helper.
package wishbone_adapter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        RDATA = 3'd3,
        WRESP = 3'd4
    } state_e;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

    // Returns {grantRead, grantWrite}; a tie goes to whichever side lost last time.
    function automatic logic [1:0] arbitrate(input logic   readPending,
                                             input logic   writePending,
                                             input grant_e lastGrant);
        logic grantRead;
        logic grantWrite;
        grantRead  = readPending  && (!writePending || lastGrant == GRANT_WRITE);
        grantWrite = writePending && (!readPending  || lastGrant == GRANT_READ);
        return {grantRead, grantWrite};
    endfunction

endpackage

// File: rtl/wishbone_bus_if.sv
// Wishbone classic bus bundle with master and slave views.
interface wishbone_bus_if #(
    parameter int adr_width = 32,
    parameter int dat_width = 32,
    parameter int sel_width = 4
);
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [adr_width-1:0] adr;
    logic [dat_width-1:0] datwr;
    logic [sel_width-1:0] sel;
    logic [dat_width-1:0] datrd;
    logic                 ack;

    modport m_modport (
        output cyc, stb, we, adr, datwr, sel,
        input  datrd, ack
    );

    modport s_modport (
        input  cyc, stb, we, adr, datwr, sel,
        output datrd, ack
    );
endinterface

// File: rtl/wishbone_hold_reg.sv
// One-entry holding register: loads when empty and offered, empties on clear.
module wishbone_hold_reg #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [width-1:0] i_d,
    output logic [width-1:0] o_q,
    output logic             o_full
);
    logic [width-1:0] r_q;
    logic             r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_q    <= i_d;
            r_full <= 1'b1;
        end
    end

    assign o_q    = r_q;
    assign o_full = r_full;
endmodule

// File: rtl/wishbone_master_adapter.sv
// Bridges split read/write valid-ready channels onto a single Wishbone master,
// one bus cycle at a time with fair read/write arbitration.
module wishbone_master_adapter
    import wishbone_adapter_pkg::*;
#(
    parameter int addr_width   = 32,
    parameter int data_width   = 32,
    parameter int strobe_width = data_width / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [addr_width-1:0]   raddr,
    input  logic                    raddr_valid,
    output logic                    raddr_ready,
    output logic [data_width-1:0]   rdata,
    output logic                    rdata_valid,
    input  logic                    rdata_ready,
    input  logic [addr_width-1:0]   waddr,
    input  logic                    waddr_valid,
    output logic                    waddr_ready,
    input  logic [data_width-1:0]   wdata,
    input  logic [strobe_width-1:0] wstrobe,
    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    output logic                    wresp_valid,
    input  logic                    wresp_ready,
    wishbone_bus_if.m_modport       wb
);
    localparam int WD_WIDTH = data_width + strobe_width;

    state_e r_state;
    state_e w_stateNext;
    grant_e r_lastGrant;

    logic                    w_addrFull;
    logic                    w_dataFull;
    logic [addr_width-1:0]   w_addrQ;
    logic [WD_WIDTH-1:0]     w_dataQ;
    logic                    w_grantRead;
    logic                    w_grantWrite;
    logic                    w_ackRead;
    logic                    w_ackWrite;

    logic                    r_cyc;
    logic                    r_stb;
    logic                    r_we;
    logic [addr_width-1:0]   r_adr;
    logic [data_width-1:0]   r_datwr;
    logic [strobe_width-1:0] r_sel;
    logic [data_width-1:0]   r_rdata;

    wishbone_hold_reg #(.width(addr_width)) u_addrHold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (waddr_valid && !w_addrFull),
        .i_clear (w_ackWrite),
        .i_d     (waddr),
        .o_q     (w_addrQ),
        .o_full  (w_addrFull)
    );

    wishbone_hold_reg #(.width(WD_WIDTH)) u_dataHold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (wdata_valid && !w_dataFull),
        .i_clear (w_ackWrite),
        .i_d     ({wstrobe, wdata}),
        .o_q     (w_dataQ),
        .o_full  (w_dataFull)
    );

    always_comb begin
        w_stateNext  = r_state;
        w_grantRead  = 1'b0;
        w_grantWrite = 1'b0;
        w_ackRead    = 1'b0;
        w_ackWrite   = 1'b0;
        case (r_state)
            IDLE: begin
                {w_grantRead, w_grantWrite} =
                    arbitrate(raddr_valid, w_addrFull && w_dataFull, r_lastGrant);
                if (w_grantRead)
                    w_stateNext = READ;
                else if (w_grantWrite)
                    w_stateNext = WRITE;
            end
            READ: begin
                if (wb.ack && r_cyc) begin
                    w_ackRead   = 1'b1;
                    w_stateNext = RDATA;
                end
            end
            WRITE: begin
                if (wb.ack && r_cyc) begin
                    w_ackWrite  = 1'b1;
                    w_stateNext = WRESP;
                end
            end
            RDATA: if (rdata_ready) w_stateNext = IDLE;
            WRESP: if (wresp_ready) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lastGrant <= GRANT_WRITE;
        end else begin
            r_state <= w_stateNext;
            if (w_grantRead)
                r_lastGrant <= GRANT_READ;
            else if (w_grantWrite)
                r_lastGrant <= GRANT_WRITE;
        end
    end

    // Bus signals are launched on the grant edge and frozen until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_datwr <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_grantRead) begin
                r_cyc <= 1'b1;
                r_stb <= 1'b1;
                r_we  <= 1'b0;
                r_adr <= raddr;
                r_sel <= '1;
            end else if (w_grantWrite) begin
                r_cyc   <= 1'b1;
                r_stb   <= 1'b1;
                r_we    <= 1'b1;
                r_adr   <= w_addrQ;
                r_datwr <= w_dataQ[data_width-1:0];
                r_sel   <= w_dataQ[data_width +: strobe_width];
            end else if (w_ackRead || w_ackWrite) begin
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
            end
            if (w_ackRead)
                r_rdata <= wb.datrd;
        end
    end

    assign raddr_ready = w_grantRead;
    assign rdata       = r_rdata;
    assign rdata_valid = (r_state == RDATA);
    assign wresp_valid = (r_state == WRESP);
    assign waddr_ready = !w_addrFull;
    assign wdata_ready = !w_dataFull;

    assign wb.cyc   = r_cyc;
    assign wb.stb   = r_stb;
    assign wb.we    = r_we;
    assign wb.adr   = r_adr;
    assign wb.datwr = r_datwr;
    assign wb.sel   = r_sel;
endmodule

// File: tb/tb_wishbone_master_adapter.sv
// Directed self-checking bench for wishbone_master_adapter; the bench plays the Wishbone slave.
module tb_wishbone_master_adapter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raddr;
    logic        raddr_valid;
    logic        raddr_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        rdata_ready;
    logic [31:0] waddr;
    logic        waddr_valid;
    logic        waddr_ready;
    logic [31:0] wdata;
    logic [3:0]  wstrobe;
    logic        wdata_valid;
    logic        wdata_ready;
    logic        wresp_valid;
    logic        wresp_ready;

    int testsRun    = 0;
    int testsFailed = 0;

    wishbone_bus_if #(.adr_width(32), .dat_width(32), .sel_width(4)) wbIf ();

    wishbone_master_adapter #(
        .addr_width   (32),
        .data_width   (32),
        .strobe_width (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raddr       (raddr),
        .raddr_valid (raddr_valid),
        .raddr_ready (raddr_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .waddr       (waddr),
        .waddr_valid (waddr_valid),
        .waddr_ready (waddr_ready),
        .wdata       (wdata),
        .wstrobe     (wstrobe),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wresp_valid (wresp_valid),
        .wresp_ready (wresp_ready),
        .wb          (wbIf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        waddr = a; wdata = d; wstrobe = s;
        waddr_valid = 1'b1; wdata_valid = 1'b1;
        tick();
        waddr_valid = 1'b0; wdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        testsRun++;
        if ({wbIf.cyc, wbIf.stb, wbIf.we} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_cyc_stb_we: got %b expected 000", {wbIf.cyc, wbIf.stb, wbIf.we});
        end
        testsRun++;
        if ({wbIf.adr, wbIf.datwr, wbIf.sel} !== 68'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_bus_fields: got %h expected 0", {wbIf.adr, wbIf.datwr, wbIf.sel});
        end
        testsRun++;
        if ({rdata_valid, wresp_valid, rdata} !== 34'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_responses: got %h expected 0", {rdata_valid, wresp_valid, rdata});
        end
        testsRun++;
        if ({waddr_ready, wdata_ready, raddr_ready} !== 3'b110) begin
            testsFailed++;
            $display("[TB] FAIL reset_readies: got %b expected 110", {waddr_ready, wdata_ready, raddr_ready});
        end
        rst = 1'b0;
    endtask

    task automatic test_read();
        raddr = 32'h100; raddr_valid = 1'b1;
        #1;
        testsRun++;
        if (raddr_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL read_accept: raddr_ready got %b expected 1", raddr_ready);
        end
        tick();
        raddr_valid = 1'b0;
        testsRun++;
        if ({wbIf.cyc, wbIf.stb, wbIf.we, wbIf.adr, wbIf.sel} !== {3'b110, 32'h100, 4'hF}) begin
            testsFailed++;
            $display("[TB] FAIL read_bus: got %h expected %h", {wbIf.cyc, wbIf.stb, wbIf.we, wbIf.adr, wbIf.sel}, {3'b110, 32'h100, 4'hF});
        end
        tick(); tick();
        testsRun++;
        if ({wbIf.cyc, wbIf.adr} !== {1'b1, 32'h100}) begin
            testsFailed++;
            $display("[TB] FAIL read_wait_stable: got %h expected %h", {wbIf.cyc, wbIf.adr}, {1'b1, 32'h100});
        end
        wbIf.ack = 1'b1; wbIf.datrd = 32'hDEADBEEF;
        tick();
        wbIf.ack = 1'b0; wbIf.datrd = 32'h0;
        testsRun++;
        if ({wbIf.cyc, rdata_valid, rdata} !== {2'b01, 32'hDEADBEEF}) begin
            testsFailed++;
            $display("[TB] FAIL read_data: got %h expected %h", {wbIf.cyc, rdata_valid, rdata}, {2'b01, 32'hDEADBEEF});
        end
        rdata_ready = 1'b1;
        tick();
        rdata_ready = 1'b0;
        testsRun++;
        if (rdata_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL read_done: rdata_valid got %b expected 0", rdata_valid);
        end
    endtask

    task automatic test_write();
        waddr = 32'h200; waddr_valid = 1'b1;
        tick();
        waddr_valid = 1'b0;
        testsRun++;
        if ({waddr_ready, wbIf.cyc} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL write_addr_only: got %b expected 00", {waddr_ready, wbIf.cyc});
        end
        wdata = 32'h12345678; wstrobe = 4'h3; wdata_valid = 1'b1;
        tick();
        wdata_valid = 1'b0;
        testsRun++;
        if ({wdata_ready, wbIf.cyc} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL write_both_held: got %b expected 00", {wdata_ready, wbIf.cyc});
        end
        tick();
        testsRun++;
        if ({wbIf.cyc, wbIf.stb, wbIf.we, wbIf.adr, wbIf.datwr, wbIf.sel} !== {3'b111, 32'h200, 32'h12345678, 4'h3}) begin
            testsFailed++;
            $display("[TB] FAIL write_bus: got %h expected %h", {wbIf.cyc, wbIf.stb, wbIf.we, wbIf.adr, wbIf.datwr, wbIf.sel}, {3'b111, 32'h200, 32'h12345678, 4'h3});
        end
        wbIf.ack = 1'b1;
        tick();
        wbIf.ack = 1'b0;
        testsRun++;
        if ({wbIf.cyc, wresp_valid, waddr_ready, wdata_ready} !== 4'b0111) begin
            testsFailed++;
            $display("[TB] FAIL write_resp: got %b expected 0111", {wbIf.cyc, wresp_valid, waddr_ready, wdata_ready});
        end
        wresp_ready = 1'b1;
        tick();
        wresp_ready = 1'b0;
        testsRun++;
        if (wresp_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL write_done: wresp_valid got %b expected 0", wresp_valid);
        end
    endtask

    task automatic test_arbitration();
        reset_dut();
        load_write(32'h400, 32'hA5A5A5A5, 4'hF);
        raddr = 32'h500; raddr_valid = 1'b1;
        #1;
        testsRun++;
        if (raddr_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL arb_first_tie_read: raddr_ready got %b expected 1", raddr_ready);
        end
        tick();
        testsRun++;
        if ({wbIf.we, wbIf.adr} !== {1'b0, 32'h500}) begin
            testsFailed++;
            $display("[TB] FAIL arb_first_read_bus: got %h expected %h", {wbIf.we, wbIf.adr}, {1'b0, 32'h500});
        end
        raddr = 32'h600;
        wbIf.ack = 1'b1; wbIf.datrd = 32'h1;
        tick();
        wbIf.ack = 1'b0;
        rdata_ready = 1'b1;
        tick();
        rdata_ready = 1'b0;
        testsRun++;
        if ({raddr_ready, wbIf.cyc} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL arb_second_tie_write: got %b expected 00", {raddr_ready, wbIf.cyc});
        end
        tick();
        testsRun++;
        if ({wbIf.cyc, wbIf.we, wbIf.adr} !== {2'b11, 32'h400}) begin
            testsFailed++;
            $display("[TB] FAIL arb_second_write_bus: got %h expected %h", {wbIf.cyc, wbIf.we, wbIf.adr}, {2'b11, 32'h400});
        end
        wbIf.ack = 1'b1;
        tick();
        wbIf.ack = 1'b0;
        waddr = 32'h700; wdata = 32'h0BADF00D; wstrobe = 4'hC;
        waddr_valid = 1'b1; wdata_valid = 1'b1; wresp_ready = 1'b1;
        tick();
        waddr_valid = 1'b0; wdata_valid = 1'b0; wresp_ready = 1'b0;
        testsRun++;
        if ({raddr_ready, waddr_ready, wdata_ready} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL arb_third_tie_read: got %b expected 100", {raddr_ready, waddr_ready, wdata_ready});
        end
        tick();
        raddr_valid = 1'b0;
        testsRun++;
        if ({wbIf.cyc, wbIf.we, wbIf.adr} !== {2'b10, 32'h600}) begin
            testsFailed++;
            $display("[TB] FAIL arb_third_read_bus: got %h expected %h", {wbIf.cyc, wbIf.we, wbIf.adr}, {2'b10, 32'h600});
        end
        reset_dut();
    endtask

    task automatic test_stall();
        reset_dut();
        raddr = 32'h300; raddr_valid = 1'b1;
        tick();
        raddr_valid = 1'b0;
        wbIf.ack = 1'b1; wbIf.datrd = 32'hCAFEF00D;
        tick();
        wbIf.ack = 1'b0; wbIf.datrd = 32'h11111111;
        waddr = 32'h800; wdata = 32'h22222222; wstrobe = 4'hF;
        waddr_valid = 1'b1; wdata_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            waddr_valid = 1'b0; wdata_valid = 1'b0;
            testsRun++;
            if ({rdata_valid, wbIf.cyc, rdata} !== {2'b10, 32'hCAFEF00D}) begin
                testsFailed++;
                $display("[TB] FAIL stall_cycle%0d: got %h expected %h", i, {rdata_valid, wbIf.cyc, rdata}, {2'b10, 32'hCAFEF00D});
            end
        end
        rdata_ready = 1'b1;
        tick();
        rdata_ready = 1'b0;
        testsRun++;
        if ({rdata_valid, wbIf.cyc} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL stall_idle_gap: got %b expected 00", {rdata_valid, wbIf.cyc});
        end
        tick();
        testsRun++;
        if ({wbIf.cyc, wbIf.we, wbIf.adr} !== {2'b11, 32'h800}) begin
            testsFailed++;
            $display("[TB] FAIL stall_write_after: got %h expected %h", {wbIf.cyc, wbIf.we, wbIf.adr}, {2'b11, 32'h800});
        end
        reset_dut();
    endtask

    task automatic test_spurious_ack();
        reset_dut();
        wbIf.ack = 1'b1; wbIf.datrd = 32'hBAD0BAD0;
        tick(); tick();
        wbIf.ack = 1'b0;
        testsRun++;
        if ({wbIf.cyc, rdata_valid, wresp_valid, rdata} !== 35'h0) begin
            testsFailed++;
            $display("[TB] FAIL spurious_ack: got %h expected 0", {wbIf.cyc, rdata_valid, wresp_valid, rdata});
        end
        raddr = 32'h900; raddr_valid = 1'b1;
        #1;
        testsRun++;
        if (raddr_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL spurious_still_idle: raddr_ready got %b expected 1", raddr_ready);
        end
        tick();
        raddr_valid = 1'b0;
        reset_dut();
    endtask

    task automatic test_reset_mid_cycle();
        load_write(32'hA00, 32'h33333333, 4'h1);
        tick();
        testsRun++;
        if ({wbIf.cyc, wbIf.we} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL midrst_started: got %b expected 11", {wbIf.cyc, wbIf.we});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        testsRun++;
        if ({wbIf.cyc, wbIf.stb, wresp_valid, rdata_valid, waddr_ready, wdata_ready, raddr_ready} !== 7'b0000110) begin
            testsFailed++;
            $display("[TB] FAIL midrst_cleared: got %b expected 0000110", {wbIf.cyc, wbIf.stb, wresp_valid, rdata_valid, waddr_ready, wdata_ready, raddr_ready});
        end
        wbIf.ack = 1'b1;
        tick();
        wbIf.ack = 1'b0;
        tick();
        testsRun++;
        if ({wbIf.cyc, wresp_valid} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL midrst_no_response: got %b expected 00", {wbIf.cyc, wresp_valid});
        end
    endtask

    initial begin
        rst = 1'b1;
        raddr = '0; raddr_valid = 1'b0; rdata_ready = 1'b0;
        waddr = '0; waddr_valid = 1'b0;
        wdata = '0; wstrobe = '0; wdata_valid = 1'b0;
        wresp_ready = 1'b0;
        wbIf.ack = 1'b0; wbIf.datrd = '0;

        test_reset();
        test_read();
        test_write();
        test_arbitration();
        test_stall();
        test_spurious_ack();
        test_reset_mid_cycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
